// File: rtl/sdram_arbiter.sv
// Two-port SDRAM arbiter: a play-side reader and a record-side writer share one Avalon-MM master.
// Define SDRAM_ARB_PLAY_PRIO_EN to give play fixed priority on ties; otherwise ties alternate round-robin.
`timescale 1ns/1ps

module sdram_arbiter (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        play_read,
    input  logic [22:0] play_addr,
    output logic [31:0] play_readdata,
    output logic        play_sdram_finished,

    input  logic        rec_write,
    input  logic [22:0] rec_addr,
    input  logic [31:0] rec_writedata,
    output logic        rec_sdram_finished,

    output logic [22:0] sdram_addr,
    output logic        sdram_read,
    output logic        sdram_write,
    output logic [31:0] sdram_writedata,
    input  logic [31:0] sdram_readdata,
    input  logic        sdram_readdatavalid,
    input  logic        sdram_waitrequest,

    output logic        grant_play
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_DONE,
        RD_DONE
    } state_t;

    state_t      state, state_n;
    logic [1:0]  rst_sync;
    logic        rst_n;
    logic        prefer_play;
    logic        grant_rd;
    logic        grant_wr;
    logic        capture;
    logic [22:0] addr_q;
    logic [31:0] wdata_q;

    // NOTE: assertion is asynchronous, release is retimed through two flops so the FSM
    // never sees a reset edge close to the clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // grant_play doubles as the round-robin pointer: it remembers who was served last.
`ifdef SDRAM_ARB_PLAY_PRIO_EN
    assign prefer_play = 1'b1;
`else
    assign prefer_play = ~grant_play;
`endif

    // NOTE: every variable gets its default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_n  = state;
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (play_read && (!rec_write || prefer_play)) begin
                    grant_rd = 1'b1;
                    state_n  = RD_REQ;
                end else if (rec_write) begin
                    grant_wr = 1'b1;
                    state_n  = WR_REQ;
                end
            end
            RD_REQ: begin
                if (!sdram_waitrequest) begin
                    if (sdram_readdatavalid) begin
                        capture = 1'b1;
                        state_n = RD_DONE;
                    end else begin
                        state_n = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (sdram_readdatavalid) begin
                    capture = 1'b1;
                    state_n = RD_DONE;
                end
            end
            WR_REQ: begin
                if (!sdram_waitrequest) begin
                    state_n = WR_DONE;
                end
            end
            WR_DONE: state_n = IDLE;
            RD_DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Request address/data are captured at grant so requester changes cannot disturb the bus.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            grant_play <= 1'b0;
        end else if (grant_rd) begin
            addr_q     <= play_addr;
            grant_play <= 1'b1;
        end else if (grant_wr) begin
            addr_q     <= rec_addr;
            wdata_q    <= rec_writedata;
            grant_play <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            play_readdata <= '0;
        end else if (capture) begin
            play_readdata <= sdram_readdata;
        end
    end

    assign sdram_read          = (state == RD_REQ);
    assign sdram_write         = (state == WR_REQ);
    assign sdram_addr          = addr_q;
    assign sdram_writedata     = wdata_q;
    assign play_sdram_finished = (state == RD_DONE);
    assign rec_sdram_finished  = (state == WR_DONE);

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have ports: i_clk in 1, system clock; i_rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have play-side ports: play_read in 1, read request; play_addr in 23, word address; play_readdata out 32, returned word; play_sdram_finished out 1, completion pulse.
REQ-003 SHALL have record-side ports: rec_write in 1, write request; rec_addr in 23, word address; rec_writedata in 32, data to store; rec_sdram_finished out 1, completion pulse.
REQ-004 SHALL have SDRAM-side ports: sdram_addr out 23; sdram_read out 1; sdram_write out 1; sdram_writedata out 32; sdram_readdata in 32; sdram_readdatavalid in 1; sdram_waitrequest in 1 (Avalon-MM pipelined semantics).
REQ-005 SHALL expose grant_play out 1, high while the current or last-served transaction is the play side (debug).

Function
REQ-006 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_DONE, RD_DONE.
REQ-007 In IDLE, SHALL sample play_read/rec_write each cycle; grant at most one per cycle; the granted request's address (and write data) SHALL be latched in the grant cycle.
REQ-008 Simultaneous requests: round-robin, the side not served last wins; after reset, play wins first tie.
REQ-009 RD_REQ: sdram_read=1, sdram_addr=latched addr; leave to RD_WAIT in the first cycle sdram_waitrequest=0.
REQ-010 RD_WAIT: capture sdram_readdata into play_readdata register on sdram_readdatavalid=1 (also accepted in RD_REQ's final cycle); then go to RD_DONE.
REQ-011 WR_REQ: sdram_write=1, sdram_addr/sdram_writedata=latched values; on sdram_waitrequest=0 go to WR_DONE.
REQ-012 RD_DONE/WR_DONE: pulse play_sdram_finished/rec_sdram_finished for exactly one cycle; no grant that cycle; return to IDLE.
REQ-013 Minimum latency, zero wait states and readdatavalid one cycle after accept: read = grant + 3 cycles to finished; write = grant + 2.
REQ-014 play_readdata SHALL hold its value until the next completed read.
REQ-015 sdram_read and sdram_write SHALL never be high in the same cycle; both low outside RD_REQ/WR_REQ.
REQ-016 A request deasserted after grant SHALL NOT abort the SDRAM transaction; finished still pulses.
REQ-017 A request held high through its finished pulse SHALL be treated as a new request in the following IDLE cycle.
REQ-018 Requester address/data changes after grant SHALL NOT affect the in-flight transaction.

Reset
REQ-019 On i_rst_n=0 (any cycle, including mid-transaction): state=IDLE, all outputs 0, play_readdata=0, round-robin pointer=play-next; SDRAM transaction in flight is abandoned.
REQ-020 Reset release is synchronised internally with a 2-flop deassertion chain; first grant possible 2 cycles after release.

Configuration
REQ-021 Macro SDRAM_ARB_PLAY_PRIO_EN: when defined, simultaneous requests always grant play (fixed priority, prevents audio underrun); when undefined, round-robin per REQ-008.

Verification
REQ-022 Play-only: play_read=1, play_addr=23'h000010, sdram_readdata=32'hDEADBEEF, no wait -> sdram_read one cycle at addr 0x10, play_readdata=0xDEADBEEF, finished pulse 3 cycles after grant.
REQ-023 Record-only with waitrequest high 4 cycles: rec_addr=23'h7FFFFF, rec_writedata=32'h12345678 -> sdram_write held 5 cycles, stable addr/data, rec_sdram_finished one pulse.
REQ-024 Simultaneous requests held continuously, macro undefined -> grants alternate play, rec, play, rec; macro defined -> play, play, play, rec never served.
REQ-025 Play request drops one cycle after grant -> read still completes, one finished pulse, play_readdata updated.
REQ-026 i_rst_n asserted during RD_WAIT -> all outputs 0 immediately, IDLE after release, next tie grants play.
REQ-027 Throughout all scenarios, assertion checks: sdram_read and sdram_write never both 1; finished pulses exactly one cycle wide.
